// File: rtl/bb_master.sv
`default_nettype none
// ==========================================================================
// bb_master : Blackbone bus initiator, FIFO-queued SETUP/ENABLE sequencer
// Rev 1.0
// ==========================================================================
module bb_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] per_addr,
  output logic              per_we,
  output logic              per_en,
  output logic [DATA_W-1:0] per_din,
  input  logic [DATA_W-1:0] per_dout
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ENABLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t state;

  logic              fifo_we   [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_data [CMD_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // Head is consumed on the last edge of a transaction so the next SETUP follows without a gap.
  assign pop       = !empty && ((state == IDLE) ||
                                (state == ENABLE && per_we) ||
                                (state == CAPTURE));
  assign busy      = !empty || (state != IDLE);

  assign head_we   = fifo_we[rd_ptr[PTR_W-1:0]];
  assign head_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_data = fifo_data[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge mclk) begin
    if (push) begin
      fifo_we[wr_ptr[PTR_W-1:0]]   <= cmd_we;
      fifo_addr[wr_ptr[PTR_W-1:0]] <= cmd_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      state     <= IDLE;
      per_en    <= 1'b1;
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      per_en    <= 1'b1;
      case (state)
        SETUP: state <= ENABLE;
        ENABLE: begin
          if (per_we) begin
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_addr  <= per_addr;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_we    <= 1'b0;
          rsp_addr  <= per_addr;
          rsp_rdata <= per_dout;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A pop always starts a new SETUP; per_din keeps the last write value across reads.
      if (pop) begin
        state    <= SETUP;
        per_en   <= 1'b0;
        per_we   <= head_we;
        per_addr <= head_addr;
        if (head_we) per_din <= head_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bb_master.sv
`default_nettype none
// Bench for bb_master: responder model, accept-time reference memory and response scoreboard.
module tb_bb_master;

  localparam int DEPTH = 4;

  logic        mclk = 1'b0;
  logic        mrst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_we;
  logic [7:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  per_addr;
  logic        per_we;
  logic        per_en;
  logic [31:0] per_din;
  logic [31:0] per_dout;

  bb_master #(.ADDR_W(8), .DATA_W(32), .CMD_DEPTH(DEPTH)) dut (
    .mclk(mclk), .mrst(mrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .per_addr(per_addr), .per_we(per_we), .per_en(per_en),
    .per_din(per_din), .per_dout(per_dout)
  );

  always #5 mclk = ~mclk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd3};
  endfunction

  // Responder: commits writes at the end of ENABLE, registers read data for CAPTURE,
  // and drives noise on per_dout in every other cycle.
  logic [31:0] smem [256];
  logic [255:0] swritten = '0;
  logic        en_prev;
  always @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      en_prev  <= 1'b1;
      per_dout <= '0;
    end else begin
      en_prev <= per_en;
      if (per_en && !en_prev && !per_we)
        per_dout <= swritten[per_addr] ? smem[per_addr] : init_val(per_addr);
      else
        per_dout <= $urandom;
      if (per_en && !en_prev && per_we) begin
        smem[per_addr]     <= per_din;
        swritten[per_addr] <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem  [logic [7:0]];
  logic [31:0] done_mem [logic [7:0]];
  bit          pe_hist [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          setup_cnt = 0;
  int          rsp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected responses are derived at accept time from an in-order memory image.
  task automatic tracker_loop();
    exp_t e;
    forever begin
      @(posedge mclk);
      if (!mrst) begin
        acc_cnt = 0;
        exp_q.delete();
        ref_mem = done_mem;
      end else if (cmd_valid && cmd_ready) begin
        e.we    = cmd_we;
        e.addr  = cmd_addr;
        e.wdata = cmd_wdata;
        if (cmd_we) begin
          e.rdata = '0;
          ref_mem[cmd_addr] = cmd_wdata;
        end else begin
          e.rdata = ref_mem.exists(cmd_addr) ? ref_mem[cmd_addr] : init_val(cmd_addr);
        end
        exp_q.push_back(e);
        acc_cnt++;
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    int   occ;
    forever begin
      @(negedge mclk);
      if (!mrst) begin
        setup_cnt = 0;
        rsp_cnt   = 0;
      end else begin
        if (!per_en) setup_cnt++;
        if (rsp_valid) begin
          rsp_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", {rsp_we, rsp_addr}, 64'h1FF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rsp_we", rsp_we, e.we);
            check("rsp_addr", rsp_addr, e.addr);
            check("rsp_rdata", rsp_rdata, e.rdata);
            if (e.we) done_mem[e.addr] = e.wdata;
          end
        end
        occ = acc_cnt - setup_cnt;
        check("cmd_ready", cmd_ready, occ < DEPTH);
        check("busy", busy, (occ > 0) || (setup_cnt > rsp_cnt));
      end
    end
  endtask

  task automatic recorder_loop();
    forever begin
      @(posedge mclk);
      #2;
      pe_hist.push_back(per_en);
    end
  endtask

  // Present a command from a negedge; returns at the negedge after it was accepted.
  task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d,
                      output logic ready_first);
    logic acc;
    int   n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    ready_first = cmd_ready;
    do begin
      acc = cmd_ready;
      @(posedge mclk);
      @(negedge mclk);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge mclk);
      n++;
    end
    if (busy || exp_q.size() != 0) check("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int   base;
    logic r;
    logic saw_low;
    int   pat1 [7];
    logic [7:0] a;

    pat1 = '{1, 0, 1, 1, 0, 1, 1};
    fork
      tracker_loop();
      monitor_loop();
      recorder_loop();
    join_none

    repeat (3) @(negedge mclk);
    check("rst_per_en", per_en, 1'b1);
    check("rst_per_we", per_we, 1'b0);
    check("rst_per_addr", per_addr, 8'h00);
    check("rst_per_din", per_din, 32'h0);
    check("rst_rsp", {rsp_valid, rsp_we, rsp_addr, rsp_rdata}, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge mclk);
    mrst = 1'b1;
    @(negedge mclk);

    // Write then read 0x10
    wait_idle();
    base = pe_hist.size() - 1;
    send(1'b1, 8'h10, 32'hDEADBEEF, r);
    cmd_valid = 1'b0;
    repeat (2) @(negedge mclk);
    send(1'b0, 8'h10, 32'h0, r);
    cmd_valid = 1'b0;
    repeat (4) @(negedge mclk);
    for (int i = 0; i < 7; i++) check($sformatf("t1_per_en[%0d]", i), pe_hist[base + 1 + i], pat1[i]);

    // Four back-to-back writes
    wait_idle();
    base = pe_hist.size() - 1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(i), 32'(i + 1), r);
      check($sformatf("t2_ready[%0d]", i), r, 1'b1);
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge mclk);
    for (int k = 0; k < 8; k++) check($sformatf("t2_per_en[%0d]", k), pe_hist[base + 2 + k], k % 2);

    // Reads back-to-back until the FIFO fills
    wait_idle();
    saw_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 8'h20 + 8'(i), 32'h0, r);
      if (!r) saw_low = 1'b1;
    end
    cmd_valid = 1'b0;
    check("t3_ready_dropped", saw_low, 1'b1);

    // Alternating write/read at the top address
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'hFF, 32'h12345678, r);
      send(1'b0, 8'hFF, 32'h0, r);
    end
    cmd_valid = 1'b0;

    // Reset during ENABLE of a write with two commands queued
    wait_idle();
    send(1'b1, 8'hA0, 32'h11111111, r);
    send(1'b1, 8'hA1, 32'h22222222, r);
    send(1'b0, 8'hA2, 32'h0, r);
    cmd_valid = 1'b0;
    check("t6_in_enable", {per_en, per_we, per_addr}, {2'b11, 8'hA0});
    #2 mrst = 1'b0;
    #1;
    check("t6_abort_per_en", per_en, 1'b1);
    check("t6_abort_rsp_valid", rsp_valid, 1'b0);
    check("t6_abort_busy", busy, 1'b0);
    @(negedge mclk);
    @(negedge mclk);
    mrst = 1'b1;
    repeat (8) @(negedge mclk);
    send(1'b0, 8'hA0, 32'h0, r);
    send(1'b0, 8'h10, 32'h0, r);
    cmd_valid = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        @(negedge mclk);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 8'h00;
          1:       a = 8'hFF;
          default: a = 8'h30 + 8'($urandom_range(0, 7));
        endcase
        send(1'($urandom_range(0, 1)), a, $urandom, r);
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
